serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal 2..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  augend; captured on the accepting edge.
REQ-006 b  input  WIDTH  addend; captured on the accepting edge.
REQ-007 cin  input  1  carry-in; captured on the accepting edge.
REQ-008 sum  output  WIDTH  registered result, LSB-first serial accumulation.
REQ-009 cout  output  1  registered final carry-out.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle completion pulse.

Function
REQ-012 The design SHALL be a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE with start=1 at an edge: capture a, b, cin into internal registers; clear bit counter; go to RUN.
REQ-014 IDLE with start=0: remain in IDLE; all outputs hold.
REQ-015 RUN: each edge processes one bit, LSB first, via full-adder with registered carry; the sum bit shifts into an internal shift register from the MSB end.
REQ-016 RUN SHALL last exactly WIDTH edges; the counter wraps to 0 on the final bit and the FSM goes to DONE.
REQ-017 On the RUN->DONE edge, sum and cout SHALL load the completed result; sum/cout never show partial results.
REQ-018 done SHALL be high only in DONE, i.e. exactly WIDTH+1 edges after the accepting edge, for one cycle.
REQ-019 DONE SHALL return to IDLE unconditionally on the next edge; start in DONE is ignored.
REQ-020 start in RUN or DONE SHALL be ignored; a, b, cin changes during RUN SHALL not affect the result.
REQ-021 sum and cout SHALL hold their last result until the next completion or reset.
REQ-022 Result SHALL equal {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
REQ-023 Back-to-back: start held high continuously SHALL yield one operation every WIDTH+2 cycles.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE and clear sum, cout, done, busy, carry, counter and shift register to 0.
REQ-025 rst SHALL take priority over start and over any in-progress RUN; an aborted operation produces no done pulse.
REQ-026 First start is accepted on the first edge with rst=0 and start=1.

Configuration
REQ-027 Macro SERIAL_ADDER_SUB_EN SHALL, when defined, add input port sub (1 bit), captured with a, b on the accepting edge.
REQ-028 With SERIAL_ADDER_SUB_EN and sub=1: b is inverted on capture, initial carry is 1, cin ignored; sum = a - b mod 2^WIDTH, cout = 1 when no borrow (a >= b).
REQ-029 With SERIAL_ADDER_SUB_EN and sub=0, or without the macro: behaviour per REQ-022; without the macro port sub does not exist.

Verification
REQ-030 WIDTH=8, a=8'h0F, b=8'h01, cin=0 -> sum=8'h10, cout=0, done high for exactly one cycle, 9 edges after accept.
REQ-031 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-032 start pulsed and a/b changed at RUN bit 3 -> ignored; result matches original operands; busy high throughout RUN and DONE.
REQ-033 rst asserted at RUN bit 4 -> next cycle IDLE, sum=0, cout=0, busy=0, no done; new start then completes normally.
REQ-034 SERIAL_ADDER_SUB_EN defined, sub=1: a=8'h05, b=8'h07 -> sum=8'hFE, cout=0; a=8'h07, b=8'h05 -> sum=8'h02, cout=1.
REQ-035 Random self-check: 1000 random a, b, cin with start held high -> every result matches REQ-022, done spacing WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_adder_if.sv
// Handshake/result bundle for serial_adder.
// SERIAL_ADDER_SUB_EN adds the 'sub' operand-mode signal.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;
   logic             done;

   modport master (
`ifdef SERIAL_ADDER_SUB_EN
      output sub,
`endif
      output start, a, b, cin,
      input  sum, cout, busy, done
   );

   modport slave (
`ifdef SERIAL_ADDER_SUB_EN
      input  sub,
`endif
      input  start, a, b, cin,
      output sum, cout, busy, done
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: IDLE -> RUN (WIDTH bits, LSB first) -> DONE.
// SERIAL_ADDER_SUB_EN enables a - b via inverted addend and carry-in 1.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   serial_adder_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state, state_n;

   logic             load, step, last;
   logic             busy, done;
   logic [WIDTH-1:0] a_r, b_r;
   logic [WIDTH-2:0] sh;
   logic [WIDTH-1:0] sh_full;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             s_bit, c_bit;
   logic             sub_c;

`ifdef SERIAL_ADDER_SUB_EN
   assign sub_c = bus.sub;
`else
   assign sub_c = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      step    = 1'b0;
      last    = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               load    = 1'b1;
               state_n = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
               last    = 1'b1;
               state_n = DONE;
            end
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign s_bit = a_r[0] ^ b_r[0] ^ carry;
   assign c_bit = (a_r[0] & b_r[0]) |
                  (a_r[0] & carry)  |
                  (b_r[0] & carry);

   // Earlier bits sit in sh; the current bit completes the word.
   assign sh_full = {s_bit, sh};

   always_ff @(posedge clk) begin
      if (rst) begin
         a_r    <= '0;
         b_r    <= '0;
         sh     <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum_r  <= '0;
         cout_r <= 1'b0;
      end else begin
         if (load) begin
            a_r   <= bus.a;
            b_r   <= sub_c ? ~bus.b : bus.b;
            carry <= sub_c ? 1'b1 : bus.cin;
            cnt   <= '0;
         end
         if (step) begin
            a_r   <= a_r >> 1;
            b_r   <= b_r >> 1;
            carry <= c_bit;
            sh    <= sh_full[WIDTH-1:1];
            cnt   <= last ? '0 : cnt + CW'(1);
         end
         if (last) begin
            sum_r  <= sh_full;
            cout_r <= c_bit;
         end
      end
   end

   assign bus.sum  = sum_r;
   assign bus.cout = cout_r;
   assign bus.busy = busy;
   assign bus.done = done;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, corner
// sequences, and randomized back-to-back operations.
module tb_serial_adder;
   localparam int W     = 8;
   localparam int NRAND = 1000;
   localparam int PER   = W + 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(W)) sif ();

   serial_adder #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] s;
      logic         c;
   } vec_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
   } op_t;

   vec_t tbl[8];
   op_t  hist[$];

   task automatic check(input string name,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One operation from IDLE; checks result, busy window and done timing.
   task automatic run_op(input string        name,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic         cin,
                         input logic [W-1:0] es,
                         input logic         ec);
      int lat;
      int pulses;
      int busy_bad;
      lat      = -1;
      pulses   = 0;
      busy_bad = 0;
      sif.a     = a;
      sif.b     = b;
      sif.cin   = cin;
      sif.start = 1'b1;
      tick;
      sif.start = 1'b0;
      if (sif.busy !== 1'b1) busy_bad++;
      for (int i = 1; i <= W + 4; i++) begin
         tick;
         if (sif.done === 1'b1) begin
            pulses++;
            // seen after edge i, so captured by edge i+1
            if (lat < 0) lat = i + 1;
         end
         if (i <= W && sif.busy !== 1'b1) busy_bad++;
         if (i > W && sif.busy !== 1'b0) busy_bad++;
      end
      check({name, " sum"}, 64'(sif.sum), 64'(es));
      check({name, " cout"}, 64'(sif.cout), 64'(ec));
      check({name, " done latency"}, 64'(lat), 64'(W + 1));
      check({name, " done pulses"}, 64'(pulses), 64'd1);
      check({name, " busy window"}, 64'(busy_bad), 64'd0);
   endtask

   initial begin
      int ndone;
      int last_e;
      int s;
      int busy_bad;
      int done_seen;
      logic [W:0] exp;
      op_t o;

      tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      tbl[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
      tbl[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
      tbl[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

      rst       = 1'b1;
      sif.start = 1'b0;
      sif.a     = '0;
      sif.b     = '0;
      sif.cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sif.sub   = 1'b0;
`endif
      repeat (3) tick;
      check("reset sum", 64'(sif.sum), 64'd0);
      check("reset cout", 64'(sif.cout), 64'd0);
      check("reset busy", 64'(sif.busy), 64'd0);
      check("reset done", 64'(sif.done), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++)
         run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b,
                tbl[i].cin, tbl[i].s, tbl[i].c);

      // idle with start low: outputs hold despite input churn
      busy_bad  = 0;
      done_seen = 0;
      for (int i = 0; i < 6; i++) begin
         sif.a = 8'(i * 37);
         sif.b = 8'(i * 91);
         tick;
         if (sif.busy !== 1'b0) busy_bad++;
         if (sif.done !== 1'b0) done_seen++;
      end
      check("idle hold sum", 64'(sif.sum), 64'(tbl[7].s));
      check("idle hold cout", 64'(sif.cout), 64'(tbl[7].c));
      check("idle busy", 64'(busy_bad), 64'd0);
      check("idle done", 64'(done_seen), 64'd0);

      // start and operand changes mid-RUN are ignored
      sif.a     = 8'h3C;
      sif.b     = 8'h21;
      sif.cin   = 1'b0;
      sif.start = 1'b1;
      tick;
      sif.start = 1'b0;
      busy_bad  = 0;
      done_seen = -1;
      for (int i = 1; i <= W + 4; i++) begin
         if (i == 4) begin
            sif.a     = 8'hFF;
            sif.b     = 8'hFF;
            sif.cin   = 1'b1;
            sif.start = 1'b1;
         end
         tick;
         if (i == 4) sif.start = 1'b0;
         if (sif.done === 1'b1 && done_seen < 0) done_seen = i + 1;
         if (i <= W && sif.busy !== 1'b1) busy_bad++;
         if (i > W && sif.busy !== 1'b0) busy_bad++;
      end
      check("midrun sum", 64'(sif.sum), 64'h5D);
      check("midrun cout", 64'(sif.cout), 64'd0);
      check("midrun busy", 64'(busy_bad), 64'd0);
      check("midrun latency", 64'(done_seen), 64'(W + 1));

      // reset during RUN aborts without a done pulse
      sif.a     = 8'h11;
      sif.b     = 8'h22;
      sif.cin   = 1'b0;
      sif.start = 1'b1;
      tick;
      sif.start = 1'b0;
      repeat (4) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("abort busy", 64'(sif.busy), 64'd0);
      check("abort sum", 64'(sif.sum), 64'd0);
      check("abort cout", 64'(sif.cout), 64'd0);
      check("abort done", 64'(sif.done), 64'd0);
      done_seen = 0;
      for (int i = 0; i < W + 4; i++) begin
         tick;
         if (sif.done !== 1'b0 || sif.busy !== 1'b0) done_seen++;
      end
      check("abort quiet", 64'(done_seen), 64'd0);
      run_op("after abort", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);

`ifdef SERIAL_ADDER_SUB_EN
      sif.sub = 1'b1;
      run_op("sub 5-7", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);
      run_op("sub 7-5", 8'h07, 8'h05, 1'b0, 8'h02, 1'b1);
      run_op("sub 0-0", 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
      sif.sub = 1'b0;
`endif

      // random back-to-back with start held high
      rst = 1'b1;
      tick;
      rst    = 1'b0;
      ndone  = 0;
      last_e = -1;
      for (int e = 0; e < NRAND * PER + PER; e++) begin
         o.a       = W'($urandom);
         o.b       = W'($urandom);
         o.cin     = 1'($urandom);
         sif.a     = o.a;
         sif.b     = o.b;
         sif.cin   = o.cin;
         sif.start = (e < NRAND * PER) ? 1'b1 : 1'b0;
         hist.push_back(o);
         tick;
         if (sif.done === 1'b1) begin
            // accepted W edges before the edge that raised done
            s = e - W;
            check("rand accept edge", 64'(s), 64'(ndone * PER));
            if (ndone > 0)
               check("rand spacing", 64'(e - last_e), 64'(PER));
            if (s >= 0 && s < hist.size()) begin
               o   = hist[s];
               exp = {1'b0, o.a} + {1'b0, o.b} + (W + 1)'(o.cin);
               check($sformatf("rand op%0d", ndone),
                     64'({sif.cout, sif.sum}), 64'(exp));
            end
            last_e = e;
            ndone++;
         end
      end
      check("rand count", 64'(ndone), 64'(NRAND));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
